// File: rtl/match_ctrl_fsm.sv
// Best-of-N match controller: sequences menu, rounds, pause, result screens and match end,
// tracking round wins, round number and the match winner. All outputs are registered.
module match_ctrl_fsm #(
  parameter int HP_W          = 8,
  parameter int WINS_W        = 2,
  parameter int WINS_TO_MATCH = 2,
  parameter int RESULT_SECS   = 5,
  parameter int MAX_ROUNDS    = 5,
  parameter int ROUND_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1s,
  input  logic              key_enter,
  input  logic              key_pause,
  input  logic [HP_W-1:0]   p1_hp,
  input  logic [HP_W-1:0]   p2_hp,
  input  logic              timer_zero,
  output logic [2:0]        state,
  output logic [WINS_W-1:0] p1_wins,
  output logic [WINS_W-1:0] p2_wins,
  output logic [ROUND_W-1:0] round_num,
  output logic              round_start,
  output logic [1:0]        match_winner
);

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_ROUND     = 3'd1,
    S_P1WIN     = 3'd2,
    S_P2WIN     = 3'd3,
    S_TIE       = 3'd4,
    S_MATCH_END = 3'd5,
    S_PAUSE     = 3'd6
  } state_t;

  localparam int HOLD_W = (RESULT_SECS > 1) ? $clog2(RESULT_SECS + 1) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESULT_SECS - 1);
  localparam logic [WINS_W-1:0]  WINS_GOAL  = WINS_W'(WINS_TO_MATCH);
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(MAX_ROUNDS);

  state_t              state_q, state_d;
  logic [WINS_W-1:0]   p1_wins_d, p2_wins_d;
  logic [ROUND_W-1:0]  round_num_d;
  logic [1:0]          match_winner_d;
  logic                round_start_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                prev_enter, prev_pause;
  logic                enter_e, pause_e;

  assign enter_e = key_enter & ~prev_enter;
  assign pause_e = key_pause & ~prev_pause;
  assign state   = state_q;

  function automatic logic [WINS_W-1:0] sat_inc(input logic [WINS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    p1_wins_d      = p1_wins;
    p2_wins_d      = p2_wins;
    round_num_d    = round_num;
    match_winner_d = match_winner;
    round_start_d  = 1'b0;
    hold_d         = hold_q;
    case (state_q)
      S_MENU: begin
        p1_wins_d      = '0;
        p2_wins_d      = '0;
        round_num_d    = '0;
        match_winner_d = 2'b00;
        if (enter_e) begin
          state_d       = S_ROUND;
          round_num_d   = ROUND_W'(1);
          round_start_d = 1'b1;
        end
      end
      S_ROUND: begin
        hold_d = '0;
        if (p1_hp == '0 && p2_hp == '0) begin
          state_d = S_TIE;
        end else if (p1_hp == '0) begin
          state_d   = S_P2WIN;
          p2_wins_d = sat_inc(p2_wins);
        end else if (p2_hp == '0) begin
          state_d   = S_P1WIN;
          p1_wins_d = sat_inc(p1_wins);
        end else if (timer_zero) begin
          state_d = S_TIE;
        end else if (pause_e) begin
          state_d = S_PAUSE;
        end
      end
      S_P1WIN, S_P2WIN, S_TIE: begin
        if (tick_1s) begin
          if (hold_q == HOLD_LAST) begin
            if (p1_wins == WINS_GOAL || p2_wins == WINS_GOAL || round_num == ROUND_LAST) begin
              state_d        = S_MATCH_END;
              match_winner_d = (p1_wins > p2_wins) ? 2'b01 :
                               (p2_wins > p1_wins) ? 2'b10 : 2'b11;
            end else begin
              state_d       = S_ROUND;
              round_num_d   = round_num + 1'b1;
              round_start_d = 1'b1;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      S_MATCH_END: begin
        if (enter_e) begin
          state_d        = S_MENU;
          p1_wins_d      = '0;
          p2_wins_d      = '0;
          round_num_d    = '0;
          match_winner_d = 2'b00;
        end
      end
      S_PAUSE: begin
        // Abort has priority over resume when both keys land together.
        if (enter_e) begin
          state_d        = S_MENU;
          p1_wins_d      = '0;
          p2_wins_d      = '0;
          round_num_d    = '0;
          match_winner_d = 2'b00;
        end else if (pause_e) begin
          state_d = S_ROUND;
        end
      end
      default: begin
        state_d        = S_MENU;
        p1_wins_d      = '0;
        p2_wins_d      = '0;
        round_num_d    = '0;
        match_winner_d = 2'b00;
        hold_d         = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_MENU;
      p1_wins      <= '0;
      p2_wins      <= '0;
      round_num    <= '0;
      match_winner <= 2'b00;
      round_start  <= 1'b0;
      hold_q       <= '0;
      prev_enter   <= 1'b1;
      prev_pause   <= 1'b1;
    end else begin
      state_q      <= state_d;
      p1_wins      <= p1_wins_d;
      p2_wins      <= p2_wins_d;
      round_num    <= round_num_d;
      match_winner <= match_winner_d;
      round_start  <= round_start_d;
      hold_q       <= hold_d;
      prev_enter   <= key_enter;
      prev_pause   <= key_pause;
    end
  end

endmodule

// File: tb/tb_match_ctrl_fsm.sv
// Scoreboard bench for match_ctrl_fsm: two instances (default and 3-win/2-second configs);
// stimulus pushes expected output snapshots, monitors pop one on every output change.
module tb_match_ctrl_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] p1;
    logic [2:0] p2;
    logic [2:0] rn;
    logic       rs;
    logic [1:0] mw;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic       tick_1s = 1'b0, key_enter = 1'b0, key_pause = 1'b0, timer_zero = 1'b0;
  logic [7:0] p1_hp = 8'd100, p2_hp = 8'd100;

  logic [2:0] a_state, b_state;
  logic [1:0] a_p1, a_p2, a_mw, b_mw;
  logic [2:0] b_p1, b_p2, a_rn, b_rn;
  logic       a_rs, b_rs;

  obs_t qa[$], qb[$];
  obs_t cur_a, cur_b, prev_a, prev_b, want_a, want_b;
  int   tests = 0, fails = 0;

  always #5 clk = ~clk;

  match_ctrl_fsm dut_a (
    .clk(clk), .rst(rst_a), .tick_1s(tick_1s), .key_enter(key_enter), .key_pause(key_pause),
    .p1_hp(p1_hp), .p2_hp(p2_hp), .timer_zero(timer_zero), .state(a_state),
    .p1_wins(a_p1), .p2_wins(a_p2), .round_num(a_rn), .round_start(a_rs), .match_winner(a_mw)
  );

  match_ctrl_fsm #(.WINS_W(3), .WINS_TO_MATCH(3), .RESULT_SECS(2)) dut_b (
    .clk(clk), .rst(rst_b), .tick_1s(tick_1s), .key_enter(key_enter), .key_pause(key_pause),
    .p1_hp(p1_hp), .p2_hp(p2_hp), .timer_zero(timer_zero), .state(b_state),
    .p1_wins(b_p1), .p2_wins(b_p2), .round_num(b_rn), .round_start(b_rs), .match_winner(b_mw)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  function automatic obs_t mk(input int st, input int p1, input int p2, input int rn,
                              input int rs, input int mw);
    obs_t o;
    o.st = 3'(st); o.p1 = 3'(p1); o.p2 = 3'(p2); o.rn = 3'(rn); o.rs = 1'(rs); o.mw = 2'(mw);
    return o;
  endfunction

  // Monitors: each output change of a DUT must match the oldest pending expectation.
  always @(negedge clk) begin
    cur_a = '{a_state, {1'b0, a_p1}, {1'b0, a_p2}, a_rn, a_rs, a_mw};
    if (rst_a) prev_a = cur_a;
    else if (cur_a !== prev_a) begin
      if (qa.size() == 0) check("a_unexpected_change", 32'(cur_a), 32'(prev_a));
      else begin
        want_a = qa.pop_front();
        check("a_event", 32'(cur_a), 32'(want_a));
      end
      prev_a = cur_a;
    end
  end

  always @(negedge clk) begin
    cur_b = '{b_state, b_p1, b_p2, b_rn, b_rs, b_mw};
    if (rst_b) prev_b = cur_b;
    else if (cur_b !== prev_b) begin
      if (qb.size() == 0) check("b_unexpected_change", 32'(cur_b), 32'(prev_b));
      else begin
        want_b = qb.pop_front();
        check("b_event", 32'(cur_b), 32'(want_b));
      end
      prev_b = cur_b;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_enter();
    key_enter = 1'b1; step(); key_enter = 1'b0; step();
  endtask

  task automatic press_pause();
    key_pause = 1'b1; step(); key_pause = 1'b0; step();
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      tick_1s = 1'b1; step(); tick_1s = 1'b0; step();
    end
  endtask

  task automatic ko(input int loser);
    if (loser == 1) p1_hp = 8'd0;
    else if (loser == 2) p2_hp = 8'd0;
    else begin p1_hp = 8'd0; p2_hp = 8'd0; end
    step();
    p1_hp = 8'd100; p2_hp = 8'd100;
    step();
  endtask

  int p1w, p2w;
  int winners[4] = '{1, 2, 1, 1};

  initial begin
    step(2);
    rst_a = 1'b0;
    step(2);
    check("a_reset_state", 32'(a_state), 0);
    check("a_reset_wins", 32'({a_p1, a_p2}), 0);
    check("a_reset_round", 32'(a_rn), 0);
    check("a_reset_pulse_winner", 32'({a_rs, a_mw}), 0);

    // Round 1 start, two P1 knockouts -> match to P1.
    qa.push_back(mk(1, 0, 0, 1, 1, 0)); qa.push_back(mk(1, 0, 0, 1, 0, 0));
    press_enter();
    qa.push_back(mk(2, 1, 0, 1, 0, 0));
    ko(2);
    tick(4);
    check("a_hold_after_4_ticks", 32'(a_state), 2);
    qa.push_back(mk(1, 1, 0, 2, 1, 0)); qa.push_back(mk(1, 1, 0, 2, 0, 0));
    tick();
    qa.push_back(mk(2, 2, 0, 2, 0, 0));
    ko(2);
    tick(4);
    qa.push_back(mk(5, 2, 0, 2, 0, 1));
    tick();
    qa.push_back(mk(0, 0, 0, 0, 0, 0));
    press_enter();

    // Five ties (double KO, then timer) -> draw at the round cap.
    qa.push_back(mk(1, 0, 0, 1, 1, 0)); qa.push_back(mk(1, 0, 0, 1, 0, 0));
    press_enter();
    for (int r = 1; r <= 5; r++) begin
      qa.push_back(mk(4, 0, 0, r, 0, 0));
      if (r == 1) ko(3);
      else begin timer_zero = 1'b1; step(); timer_zero = 1'b0; step(); end
      tick(4);
      if (r < 5) begin
        qa.push_back(mk(1, 0, 0, r + 1, 1, 0)); qa.push_back(mk(1, 0, 0, r + 1, 0, 0));
      end else qa.push_back(mk(5, 0, 0, 5, 0, 3));
      tick();
    end
    qa.push_back(mk(0, 0, 0, 0, 0, 0));
    press_enter();

    // Pause ignores a KO, resumes without a pulse, then enter+pause aborts to menu.
    qa.push_back(mk(1, 0, 0, 1, 1, 0)); qa.push_back(mk(1, 0, 0, 1, 0, 0));
    press_enter();
    qa.push_back(mk(6, 0, 0, 1, 0, 0));
    press_pause();
    p1_hp = 8'd0; step(3); p1_hp = 8'd100; step();
    qa.push_back(mk(1, 0, 0, 1, 0, 0));
    press_pause();
    qa.push_back(mk(6, 0, 0, 1, 0, 0));
    press_pause();
    qa.push_back(mk(0, 0, 0, 0, 0, 0));
    key_enter = 1'b1; key_pause = 1'b1; step();
    key_enter = 1'b0; key_pause = 1'b0; step();

    // Enter held through reset release must not start a match.
    rst_a = 1'b1; key_enter = 1'b1; step(2);
    rst_a = 1'b0; step(4);
    check("a_held_key_no_start", 32'(a_state), 0);
    key_enter = 1'b0; step();
    qa.push_back(mk(1, 0, 0, 1, 1, 0)); qa.push_back(mk(1, 0, 0, 1, 0, 0));
    press_enter();
    step(2);
    check("a_queue_drained", 32'(qa.size()), 0);
    rst_a = 1'b1;

    // Config B: P1, P2, P1, P1 -> match end after round 4 at 3/1.
    step();
    rst_b = 1'b0;
    step(2);
    p1w = 0; p2w = 0;
    qb.push_back(mk(1, 0, 0, 1, 1, 0)); qb.push_back(mk(1, 0, 0, 1, 0, 0));
    press_enter();
    for (int r = 1; r <= 4; r++) begin
      if (winners[r-1] == 1) p1w++; else p2w++;
      qb.push_back(mk(winners[r-1] == 1 ? 2 : 3, p1w, p2w, r, 0, 0));
      ko(winners[r-1] == 1 ? 2 : 1);
      tick();
      check("b_hold_after_1_tick", 32'(b_state), winners[r-1] == 1 ? 2 : 3);
      if (r < 4) begin
        qb.push_back(mk(1, p1w, p2w, r + 1, 1, 0)); qb.push_back(mk(1, p1w, p2w, r + 1, 0, 0));
      end else qb.push_back(mk(5, 3, 1, 4, 0, 1));
      tick();
    end
    qb.push_back(mk(0, 0, 0, 0, 0, 0));
    press_enter();

    // Reset asserted during P2WIN.
    qb.push_back(mk(1, 0, 0, 1, 1, 0)); qb.push_back(mk(1, 0, 0, 1, 0, 0));
    press_enter();
    qb.push_back(mk(3, 0, 1, 1, 0, 0));
    ko(1);
    rst_b = 1'b1;
    #1;
    check("b_rst_state", 32'(b_state), 0);
    check("b_rst_wins", 32'({b_p1, b_p2}), 0);
    check("b_rst_round", 32'(b_rn), 0);
    check("b_rst_pulse_winner", 32'({b_rs, b_mw}), 0);
    step(2);
    check("b_queue_drained", 32'(qb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/match_ctrl_fsm.md
Name: match_ctrl_fsm

Overview:
Parametrised best-of-N match controller for the two-player fighting game. It sequences menu, round play, pause, per-round result screens and match end. It counts round wins and rounds played, and flags the match winner for the display and scoreboard logic. The whole block runs on the single system clock: second-based timing comes from a tick_1s enable, and the block never switches clocks.

Parameters:
HP_W, 8, width of each player HP input.
WINS_W, 2, width of each round-win counter; WINS_TO_MATCH must be <= 2^WINS_W-1.
WINS_TO_MATCH, 2, round wins needed to take the match.
RESULT_SECS, 5, seconds a result screen (P1WIN/P2WIN/TIE) is held; must be >= 1.
MAX_ROUNDS, 5, round cap; finishing this round always ends the match.
ROUND_W, 3, width of round_num; MAX_ROUNDS must be <= 2^ROUND_W-1.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick_1s  in  1  one-clk pulse once per second
key_enter  in  1  enter key level (edge-detected internally)
key_pause  in  1  pause key level (edge-detected internally)
p1_hp  in  HP_W  player 1 HP
p2_hp  in  HP_W  player 2 HP
timer_zero  in  1  round timer expired (level)
state  out  3  MENU=0, ROUND=1, P1WIN=2, P2WIN=3, TIE=4, MATCH_END=5, PAUSE=6
p1_wins  out  WINS_W  player 1 rounds won
p2_wins  out  WINS_W  player 2 rounds won
round_num  out  ROUND_W  current round number, 1-based; 0 in MENU
round_start  out  1  one-clk pulse on every entry to ROUND from MENU or a result state
match_winner  out  2  00 none, 01 P1, 10 P2, 11 draw; valid in MATCH_END

Behaviour:
- Reset values: state=MENU; p1_wins, p2_wins, round_num, match_winner, round_start, hold counter = 0; previous-key registers = 1. The reset-to-1 means a key held across reset does not fire.
- Edge detection: enter_e = key_enter & ~prev_enter; pause_e is formed the same way. Both are registered every clk.
- Registered outputs: all outputs are registered. A transition decided in cycle N is visible in cycle N+1, and round_start is high in that same cycle N+1.
- MENU:
  - enter_e -> ROUND, round_num=1, wins=0, match_winner=00, round_start pulse.
  - Otherwise wins, round_num and match_winner are held at 0.
- ROUND, checks in priority order:
  1. p1_hp==0 and p2_hp==0 -> TIE (double KO).
  2. p1_hp==0 -> P2WIN, p2_wins+1.
  3. p2_hp==0 -> P1WIN, p1_wins+1.
  4. timer_zero -> TIE.
  5. pause_e -> PAUSE.
- Win counters saturate at 2^WINS_W-1.
- PAUSE:
  - enter_e -> MENU, clearing wins, round_num and match_winner (abort). enter_e wins if it coincides with pause_e.
  - pause_e alone -> ROUND with no round_start pulse.
  - HP and timer inputs are ignored while in PAUSE.
- Result states (P1WIN/P2WIN/TIE):
  - The hold counter clears on entry and increments on each tick_1s.
  - On the tick where the counter equals RESULT_SECS-1, the block leaves the state. A tick_1s in the entry cycle is not counted.
  - Exit to MATCH_END if p1_wins==WINS_TO_MATCH, p2_wins==WINS_TO_MATCH, or round_num==MAX_ROUNDS.
  - Otherwise exit to ROUND with round_num+1 and a round_start pulse.
  - Keys are ignored in result states.
- MATCH_END:
  - On entry, match_winner = 01 if p1_wins>p2_wins, 10 if p2_wins>p1_wins, else 11.
  - enter_e -> MENU and clears everything.
- Illegal state encoding 7 -> MENU on the next clk, with all counters cleared.
- Reset asserted mid-operation returns everything to reset values immediately. The block returns no result and produces no pulse during reset.

Test Plan:
- Reset, then press enter -> state 0->1, round_start high for exactly one clk, round_num=1, wins 0/0.
- Default parameters, p2_hp=0 in round 1 -> P1WIN with p1_wins=1. After exactly 5 tick_1s pulses -> ROUND, round_num=2, round_start pulse. A second p2 KO -> P1WIN, then after 5 ticks -> MATCH_END with match_winner=01.
- p1_hp=0 and p2_hp=0 in the same clk -> TIE and neither counter changes. timer_zero alone -> TIE. Five consecutive ties with MAX_ROUNDS=5 -> MATCH_END with match_winner=11.
- pause_e in ROUND -> PAUSE, and a p1_hp=0 input is ignored. pause_e again -> ROUND with no round_start. Enter and pause pressed in the same clk while in PAUSE -> MENU with wins cleared.
- key_enter held high through reset release -> no transition out of MENU until the key is released and pressed again.
- WINS_W=3, WINS_TO_MATCH=3, RESULT_SECS=2: P1, P2, P1, P1 rounds -> MATCH_END after round 4 with wins 3/1. Each result state lasts exactly 2 ticks. Asserting rst during P2WIN -> MENU with all outputs at 0.
